// File: rtl/adc_seq_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the parallel-ADC sequencer.
package adc_seq_pkg;

    localparam int TS_W = 32;

    typedef enum logic [2:0] {
        ADC_RST = 3'd0,
        IDLE    = 3'd1,
        CONV    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        READ    = 3'd5
    } state_e;

    function automatic int cmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
`timescale 1ns/1ps
// Synchronous first-word-fall-through FIFO with free-slot count.
module adc_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [AW:0]      free_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO may still accept a word when the head leaves in the same clock.
    assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign free_o  = (AW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/adc_par_sequencer.sv
`timescale 1ns/1ps
// Parallel-ADC conversion sequencer: paces convst, reads NUM_CH words per frame into an FWFT stream FIFO.
// Define ADC_TIMESTAMP_EN to tag every word with a 32-bit frame counter on s_tstamp.
module adc_par_sequencer
    import adc_seq_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 8,
    parameter int FIFO_DEPTH   = 32,
    parameter int SAMPLE_DIV   = 540,
    parameter int CONVST_LOW   = 2,
    parameter int RD_LOW       = 2,
    parameter int RD_HIGH      = 1,
    parameter int ADCRST_CYC   = 8,
    parameter int BUSY_TIMEOUT = 64,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLOCK_27M,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] DB,
    input  logic              Busy,
    output logic              convst,
    output logic              ADC_CS_N,
    output logic              RD_N,
    output logic              ADCrst,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] s_data,
    output logic [CH_W-1:0]   s_chan,
    output logic              s_last,
`ifdef ADC_TIMESTAMP_EN
    output logic [TS_W-1:0]   s_tstamp,
`endif
    output logic              ovf,
    output logic              busy_err,
    input  logic              flag_clr
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(cmax(cmax(ADCRST_CYC, BUSY_TIMEOUT),
                                       cmax(cmax(CONVST_LOW, RD_LOW), RD_HIGH)) + 1);
    localparam int FCW   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    typedef struct packed {
`ifdef ADC_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   chan;
        logic              last;
    } entry_t;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CH_W-1:0]  ch_q;
    logic             rd_hi_q;
    logic             convst_q, cs_n_q, rd_n_q, adcrst_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       busy_sync_q;
    logic             ovf_q, ovf_d, busy_err_q, busy_err_d;
    logic             busy_s, tick, start, push, busy_to;
    logic [FCW-1:0]   fifo_free;
    entry_t           wr_ent, rd_ent;

    assign busy_s  = busy_sync_q[1];
    assign tick    = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign start   = (state_q == IDLE) && tick && (fifo_free >= FCW'(NUM_CH));
    assign push    = (state_q == READ) && !rd_hi_q && (cnt_q == CNT_W'(RD_LOW - 1));
    assign busy_to = (state_q == WAIT_HI) && !busy_s && (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        div_d = div_q + 1'b1;
        if (!enable || tick) div_d = '0;
    end

    // Setting a flag takes priority over clearing it in the same clock.
    always_comb begin
        ovf_d      = ovf_q;
        busy_err_d = busy_err_q;
        if (flag_clr) begin
            ovf_d      = 1'b0;
            busy_err_d = 1'b0;
        end
        if (tick && !start) ovf_d = 1'b1;
        if (busy_to) busy_err_d = 1'b1;
    end

    always_ff @(posedge CLOCK_27M) begin
        if (rst) begin
            div_q       <= '0;
            busy_sync_q <= '0;
            ovf_q       <= 1'b0;
            busy_err_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            busy_sync_q <= {busy_sync_q[0], Busy};
            ovf_q       <= ovf_d;
            busy_err_q  <= busy_err_d;
        end
    end

    always_ff @(posedge CLOCK_27M) begin
        if (rst) begin
            state_q  <= ADC_RST;
            cnt_q    <= '0;
            ch_q     <= '0;
            rd_hi_q  <= 1'b0;
            convst_q <= 1'b1;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            adcrst_q <= 1'b1;
        end else begin
            case (state_q)
                ADC_RST: begin
                    if (cnt_q == CNT_W'(ADCRST_CYC - 1)) begin
                        adcrst_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (start) begin
                        convst_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    if (cnt_q == CNT_W'(CONVST_LOW - 1)) begin
                        convst_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= WAIT_HI;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (busy_s)       state_q <= WAIT_LO;
                    else if (busy_to) state_q <= IDLE;
                    else              cnt_q   <= cnt_q + 1'b1;
                end
                WAIT_LO: begin
                    if (!busy_s) begin
                        cs_n_q  <= 1'b0;
                        rd_n_q  <= 1'b0;
                        rd_hi_q <= 1'b0;
                        ch_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (!rd_hi_q) begin
                        if (cnt_q == CNT_W'(RD_LOW - 1)) begin
                            rd_n_q  <= 1'b1;
                            rd_hi_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (cnt_q == CNT_W'(RD_HIGH - 1)) begin
                        cnt_q <= '0;
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            cs_n_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            rd_hi_q <= 1'b0;
                            rd_n_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ADC_RST;
            endcase
        end
    end

`ifdef ADC_TIMESTAMP_EN
    logic [TS_W-1:0] frame_cnt_q, frame_ts_q;

    always_ff @(posedge CLOCK_27M) begin
        if (rst) begin
            frame_cnt_q <= '0;
            frame_ts_q  <= '0;
        end else if (start) begin
            frame_ts_q  <= frame_cnt_q;
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        wr_ent      = '0;
        wr_ent.data = DB;
        wr_ent.chan = ch_q;
        wr_ent.last = (ch_q == CH_W'(NUM_CH - 1));
`ifdef ADC_TIMESTAMP_EN
        wr_ent.ts   = frame_ts_q;
`endif
    end

    adc_seq_fifo #(
        .WIDTH (DATA_W + CH_W + 1
`ifdef ADC_TIMESTAMP_EN
                + TS_W
`endif
        ),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK_27M),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (wr_ent),
        .pop_i   (s_valid && s_ready),
        .rdata_o (rd_ent),
        .valid_o (s_valid),
        .free_o  (fifo_free)
    );

    assign s_data   = rd_ent.data;
    assign s_chan   = rd_ent.chan;
    assign s_last   = rd_ent.last;
`ifdef ADC_TIMESTAMP_EN
    assign s_tstamp = rd_ent.ts;
`endif
    assign convst   = convst_q;
    assign ADC_CS_N = cs_n_q;
    assign RD_N     = rd_n_q;
    assign ADCrst   = adcrst_q;
    assign ovf      = ovf_q;
    assign busy_err = busy_err_q;

endmodule

// File: tb/tb_adc_par_sequencer.sv
`timescale 1ns/1ps
// Randomised bench for adc_par_sequencer: ADC bus model feeds a scoreboard checked by a stream monitor.
module tb_adc_par_sequencer;
    localparam int DATA_W = 16;
    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DIV    = 540;

    logic CLOCK_27M = 1'b0;
    logic rst = 1'b1, enable = 1'b0, Busy = 1'b0, s_ready = 1'b0, flag_clr = 1'b0;
    logic [DATA_W-1:0] DB = '0;
    logic convst, ADC_CS_N, RD_N, ADCrst, s_valid, s_last, ovf, busy_err;
    logic [DATA_W-1:0] s_data;
    logic [CH_W-1:0] s_chan;
`ifdef ADC_TIMESTAMP_EN
    logic [31:0] s_tstamp;
`endif

    adc_par_sequencer dut (
        .CLOCK_27M(CLOCK_27M), .rst(rst), .enable(enable), .DB(DB), .Busy(Busy),
        .convst(convst), .ADC_CS_N(ADC_CS_N), .RD_N(RD_N), .ADCrst(ADCrst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_chan(s_chan), .s_last(s_last),
`ifdef ADC_TIMESTAMP_EN
        .s_tstamp(s_tstamp),
`endif
        .ovf(ovf), .busy_err(busy_err), .flag_clr(flag_clr)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        int                ch;
        bit                last;
        int unsigned       ts;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, popped = 0, conv_falls = 0, rd_idx = 0, cs_low_cyc = 0;
    int prev_fall_cyc = 0, last_fall_cyc = 0, conv_rise_cyc = 0, berr_rise_cyc = 0;
    int unsigned ts_cnt = 0, cur_ts = 0;
    int rdy_mode = 1;
    bit busy_en = 1, busy_rand = 0, db_rand = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial forever #5 CLOCK_27M = ~CLOCK_27M;

    // Consumer: ready held low, high, or random per clock.
    initial forever begin
        @(posedge CLOCK_27M);
        #1;
        case (rdy_mode)
            0:       s_ready = 1'b0;
            1:       s_ready = 1'b1;
            default: s_ready = 1'($urandom_range(1, 0));
        endcase
    end

    // ADC busy model: Busy pulses a while after each conversion start.
    initial forever begin
        @(posedge convst);
        if (busy_en && rst === 1'b0) begin
            repeat (busy_rand ? $urandom_range(20, 1) : 10) @(posedge CLOCK_27M);
            #1 Busy = 1'b1;
            repeat (busy_rand ? $urandom_range(25, 1) : 6) @(posedge CLOCK_27M);
            #1 Busy = 1'b0;
        end
    end

    // ADC data bus model: each read strobe presents a new word and records what the stream must deliver.
    initial forever begin
        @(negedge RD_N or posedge ADC_CS_N);
        if (ADC_CS_N === 1'b1) begin
            rd_idx = 0;
        end else begin
            DB = db_rand ? DATA_W'($urandom) : DATA_W'(16'h0100 + rd_idx);
            exp_q.push_back('{d: DB, ch: rd_idx, last: (rd_idx == NUM_CH - 1), ts: cur_ts});
            rd_idx++;
        end
    end

    // Monitor: edge bookkeeping plus scoreboard compare on every stream handshake.
    initial begin
        bit prev_convst = 1'b1, prev_berr = 1'b0, hold = 1'b0;
        logic [DATA_W-1:0] hold_d = '0;
        logic [CH_W-1:0] hold_c = '0;
        exp_t e;
        forever begin
            @(negedge CLOCK_27M);
            cyc++;
            if (rst) begin
                exp_q.delete();
                ts_cnt = 0;
                hold = 1'b0;
            end else begin
                if (prev_convst && !convst) begin
                    cur_ts = ts_cnt;
                    ts_cnt++;
                    conv_falls++;
                    prev_fall_cyc = last_fall_cyc;
                    last_fall_cyc = cyc;
                end
                if (!prev_convst && convst) conv_rise_cyc = cyc;
                if (!prev_berr && busy_err) berr_rise_cyc = cyc;
                if (!ADC_CS_N) cs_low_cyc++;
                if (hold && s_valid) begin
                    chk("stall_stable_data", s_data, hold_d);
                    chk("stall_stable_chan", s_chan, hold_c);
                end
                if (s_valid && s_ready) begin
                    popped++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("s_data", s_data, e.d);
                        chk("s_chan", s_chan, e.ch);
                        chk("s_last", s_last, e.last);
`ifdef ADC_TIMESTAMP_EN
                        chk("s_tstamp", s_tstamp, e.ts);
`endif
                    end
                end
                hold   = s_valid && !s_ready;
                hold_d = s_data;
                hold_c = s_chan;
            end
            prev_convst = convst;
            prev_berr   = busy_err;
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge CLOCK_27M);
        #1;
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        clocks(1);
        flag_clr = 1'b0;
    endtask

    initial begin
        int n, bad, base_f, base_p, base_cs, wait_n;

        // Reset and ADC reset pulse width
        clocks(3);
        rst = 1'b0;
        n = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_27M);
            if (ADCrst) n++;
            if (!convst || !ADC_CS_N || !RD_N || s_valid || ovf || busy_err) bad++;
        end
        chk("adcrst_cycles", n, 8);
        chk("idle_outputs_after_reset", bad, 0);

        // Fixed pattern frames, always-ready consumer
        @(posedge CLOCK_27M);
        #1 enable = 1'b1;
        wait_n = 0;
        while (conv_falls < 3 && wait_n < 3 * DIV + 200) begin
            clocks(1);
            wait_n++;
        end
        chk("three_triggers_seen", conv_falls >= 3, 1);
        clocks(150);
        chk("pattern_words_popped", popped, 24);
        chk("trigger_period", last_fall_cyc - prev_fall_cyc, DIV);

        // Random data, random Busy timing, random back-pressure
        db_rand = 1;
        busy_rand = 1;
        rdy_mode = 2;
        base_f = conv_falls;
        clocks(5 * DIV);
        chk("random_frames_started", conv_falls - base_f, 5);
        chk("random_no_ovf", ovf, 0);
        chk("random_no_busy_err", busy_err, 0);
        enable = 1'b0;
        clocks(1000);
        chk("drained_before_fill", exp_q.size(), 0);

        // Stalled consumer: four frames fill the FIFO, the fifth is dropped
        rdy_mode = 0;
        base_f = conv_falls;
        base_p = popped;
        enable = 1'b1;
        clocks(5 * DIV + 60);
        chk("fill_frames_started", conv_falls - base_f, 4);
        chk("fill_ovf_set", ovf, 1);
        chk("fill_words_held", exp_q.size(), 32);
        chk("fill_valid", s_valid, 1);
        pulse_clr();
        @(negedge CLOCK_27M);
        chk("ovf_cleared", ovf, 0);
        rdy_mode = 1;
        clocks(100);
        chk("fill_words_drained", popped - base_p, 32);
        chk("fill_empty", s_valid, 0);
        enable = 1'b0;
        clocks(700);

        // Busy never rises: timeout, no read, retry on next tick
        busy_en = 0;
        pulse_clr();
        base_f = conv_falls;
        base_cs = cs_low_cyc;
        enable = 1'b1;
        clocks(DIV + 100);
        chk("busy_err_set", busy_err, 1);
        chk("busy_timeout_delay", berr_rise_cyc - conv_rise_cyc, 64);
        chk("no_cs_on_timeout", cs_low_cyc - base_cs, 0);
        clocks(DIV);
        chk("retry_after_timeout", conv_falls - base_f, 2);
        chk("timeout_no_ovf", ovf, 0);
        enable = 1'b0;
        busy_en = 1;
        clocks(200);
        pulse_clr();

        // Reset in the middle of reading channel 3
        rdy_mode = 0;
        enable = 1'b1;
        wait_n = 0;
        while (rd_idx < 4 && wait_n < 2 * DIV) begin
            @(posedge CLOCK_27M);
            wait_n++;
        end
        chk("reached_ch3", rd_idx >= 4, 1);
        #1 rst = 1'b1;
        @(posedge CLOCK_27M);
        @(negedge CLOCK_27M);
        chk("rst_convst", convst, 1);
        chk("rst_cs_n", ADC_CS_N, 1);
        chk("rst_rd_n", RD_N, 1);
        chk("rst_adcrst", ADCrst, 1);
        chk("rst_s_valid", s_valid, 0);
        clocks(2);
        rst = 1'b0;
        rdy_mode = 1;
        base_p = popped;
        clocks(3 * DIV + 150);
        chk("restart_words", popped - base_p, 24);
        enable = 1'b0;
        clocks(200);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_ovf", ovf, 0);
        chk("final_busy_err", busy_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
